// File: rtl/cache_perf_monitor_pkg.sv
// Shared constants and types for the cache performance monitor:
// counter indices, readout selects and FSM state encoding.
package cache_perf_pkg;

  localparam int NUM_CNT   = 6;
  localparam int IDX_CYC   = 0;
  localparam int IDX_REQ   = 1;
  localparam int IDX_HIT   = 2;
  localparam int IDX_MISS  = 3;
  localparam int IDX_WR    = 4;
  localparam int IDX_STALL = 5;

  localparam int SEL_MAX_STALL = 6;
  localparam int SEL_STATUS    = 7;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/cache_perf_monitor_if.sv
// Request/stall handshake between the trace source and the cache control unit.
// The monitor only observes, so its side (slave) is input-only.
interface cache_perf_monitor_if;
  logic req_valid;
  logic req_write;
  logic stall;

  modport master (output req_valid, output req_write, output stall);
  modport slave  (input  req_valid, input  req_write, input  stall);
endinterface

// File: rtl/cache_perf_monitor_counter.sv
// Single event counter with sticky overflow flag; clamps or wraps at all-ones.
module perf_counter #(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             ovf
);

  logic [WIDTH-1:0] count_reg;
  logic             ovf_reg;

  // Count events; on an increment at all-ones, flag overflow and clamp or wrap.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else if (inc) begin
      if (&count_reg) begin
        ovf_reg   <= 1'b1;
        count_reg <= SATURATE ? count_reg : '0;
      end else begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  assign count = count_reg;
  assign ovf   = ovf_reg;

endmodule

// File: rtl/cache_perf_monitor.sv
// Cache performance monitor: classifies retired requests as hit/miss,
// counts events and stall cycles, tracks the longest stall and exposes a
// registered readout mux. The FSM runs regardless of en so that
// classification survives enable toggles; only counting is gated.
module cache_perf_monitor
  import cache_perf_pkg::*;
#(
  parameter int CNT_WIDTH   = 16,
  parameter int STALL_WIDTH = 8,
  parameter bit SATURATE    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  cache_perf_monitor_if.slave  bus,
  input  logic [2:0]           sel,
  output logic [CNT_WIDTH-1:0] rd_data,
  output logic [NUM_CNT-1:0]   ovf,
  output logic                 proto_err,
  output logic                 busy
);

  state_t                 state_reg, state_next;
  logic [STALL_WIDTH-1:0] cur_stall_reg, cur_stall_next;
  logic [STALL_WIDTH-1:0] max_stall_reg;
  logic                   proto_err_reg, proto_err_next;
  logic                   retire_hit, retire_miss;
  logic [NUM_CNT-1:0]     inc;
  logic [NUM_CNT-1:0]     ovf_bits;
  logic [CNT_WIDTH-1:0]   cnt    [NUM_CNT];
  logic [CNT_WIDTH-1:0]   rd_mux [8];
  logic [CNT_WIDTH-1:0]   rd_data_reg;
  logic [7:0]             status;

  // FSM state, stall-length and protocol-error registers.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      state_reg     <= IDLE;
      cur_stall_reg <= '0;
      proto_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cur_stall_reg <= cur_stall_next;
      proto_err_reg <= proto_err_next;
    end
  end

  // Next-state logic and retire classification.
  always_comb begin
    state_next     = state_reg;
    cur_stall_next = cur_stall_reg;
    proto_err_next = proto_err_reg;
    retire_hit     = 1'b0;
    retire_miss    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.req_valid && !bus.stall) begin
          retire_hit = 1'b1;
        end else if (bus.req_valid && bus.stall) begin
          state_next     = WAIT;
          cur_stall_next = STALL_WIDTH'(1);
        end
      end
      WAIT: begin
        if (bus.req_valid && bus.stall) begin
          // Stall length always clamps; it must never alias back to short.
          if (!(&cur_stall_reg)) cur_stall_next = cur_stall_reg + 1'b1;
        end else if (bus.req_valid) begin
          retire_miss = 1'b1;
          state_next  = IDLE;
        end else begin
          proto_err_next = 1'b1;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Longest stall seen at a miss retire, updated only while enabled.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      max_stall_reg <= '0;
    end else if (en && retire_miss && (cur_stall_reg > max_stall_reg)) begin
      max_stall_reg <= cur_stall_reg;
    end
  end

  assign inc[IDX_CYC]   = en;
  assign inc[IDX_REQ]   = en && (retire_hit || retire_miss);
  assign inc[IDX_HIT]   = en && retire_hit;
  assign inc[IDX_MISS]  = en && retire_miss;
  assign inc[IDX_WR]    = en && (retire_hit || retire_miss) && bus.req_write;
  assign inc[IDX_STALL] = en && bus.req_valid && bus.stall;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      perf_counter #(
        .WIDTH    (CNT_WIDTH),
        .SATURATE (SATURATE)
      ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (inc[gi]),
        .count (cnt[gi]),
        .ovf   (ovf_bits[gi])
      );
      assign rd_mux[gi] = cnt[gi];
    end
  endgenerate

  assign status                = {proto_err_reg, (state_reg == WAIT), ovf_bits};
  assign rd_mux[SEL_MAX_STALL] = CNT_WIDTH'(max_stall_reg);
  assign rd_mux[SEL_STATUS]    = CNT_WIDTH'(status);

  // Registered readout; keeps tracking sel even while counting is disabled.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= rd_mux[sel];
    end
  end

  assign rd_data   = rd_data_reg;
  assign ovf       = ovf_bits;
  assign proto_err = proto_err_reg;
  assign busy      = (state_reg == WAIT);

endmodule

// File: tb/tb_cache_perf_monitor.sv
// Directed testbench for cache_perf_monitor. Three instances share stimulus:
// a 16-bit saturating one, plus 4-bit saturating and 4-bit wrapping ones
// used for the overflow cases.
module tb_cache_perf_monitor;
  import cache_perf_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic        clr = 1'b0;
  logic [2:0]  sel = 3'd0;

  logic [15:0] rd_a;
  logic [3:0]  rd_s, rd_w;
  logic [5:0]  ovf_a, ovf_s, ovf_w;
  logic        pe_a, pe_s, pe_w;
  logic        busy_a, busy_s, busy_w;

  int total = 0;
  int bad   = 0;

  cache_perf_monitor_if bus_if ();

  cache_perf_monitor #(.CNT_WIDTH(16), .STALL_WIDTH(8), .SATURATE(1'b1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .bus(bus_if), .sel(sel),
    .rd_data(rd_a), .ovf(ovf_a), .proto_err(pe_a), .busy(busy_a)
  );

  cache_perf_monitor #(.CNT_WIDTH(4), .STALL_WIDTH(8), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .bus(bus_if), .sel(sel),
    .rd_data(rd_s), .ovf(ovf_s), .proto_err(pe_s), .busy(busy_s)
  );

  cache_perf_monitor #(.CNT_WIDTH(4), .STALL_WIDTH(8), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .bus(bus_if), .sel(sel),
    .rd_data(rd_w), .ovf(ovf_w), .proto_err(pe_w), .busy(busy_w)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic s);
    bus_if.req_valid = v;
    bus_if.req_write = w;
    bus_if.stall     = s;
  endtask

  task automatic do_clr();
    drive(1'b0, 1'b0, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Select a readout, wait the one-cycle latency, compare the 16-bit instance.
  task automatic rd_chk(input string tag, input int s, input logic [31:0] exp);
    sel = 3'(s);
    tick();
    check_val(tag, 32'(rd_a), exp);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    en  = 1'b1;
    tick();
    tick();
    check_val("rst_rd",   32'(rd_a),   0);
    check_val("rst_ovf",  32'(ovf_a),  0);
    check_val("rst_busy", 32'(busy_a), 0);
    check_val("rst_perr", 32'(pe_a),   0);

    // Four back-to-back hits, writes on the 2nd and 4th
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b0); tick();
    en = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    rd_chk("t1_cyc",   IDX_CYC,   4);
    rd_chk("t1_req",   IDX_REQ,   4);
    rd_chk("t1_hit",   IDX_HIT,   4);
    rd_chk("t1_miss",  IDX_MISS,  0);
    rd_chk("t1_wr",    IDX_WR,    2);
    rd_chk("t1_stall", IDX_STALL, 0);

    // Two misses: stalled 3 cycles then 1 cycle; second retire is a write
    do_clr();
    en = 1'b1;
    drive(1'b1, 1'b0, 1'b1); tick(); tick(); tick();
    check_val("t2_busy", 32'(busy_a), 1);
    drive(1'b1, 1'b0, 1'b0); tick();
    check_val("t2_idle", 32'(busy_a), 0);
    drive(1'b1, 1'b0, 1'b1); tick();
    drive(1'b1, 1'b1, 1'b0); tick();
    en = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    rd_chk("t2_cyc",   IDX_CYC,       6);
    rd_chk("t2_req",   IDX_REQ,       2);
    rd_chk("t2_hit",   IDX_HIT,       0);
    rd_chk("t2_miss",  IDX_MISS,      2);
    rd_chk("t2_wr",    IDX_WR,        1);
    rd_chk("t2_stall", IDX_STALL,     4);
    rd_chk("t2_max",   SEL_MAX_STALL, 3);

    // 20 hits: 4-bit counters saturate or wrap
    do_clr();
    en = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    repeat (20) tick();
    en = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    sel = 3'(IDX_REQ);
    tick();
    check_val("t3_req_a",  32'(rd_a), 20);
    check_val("t3_req_s",  32'(rd_s), 15);
    check_val("t3_req_w",  32'(rd_w), 4);
    sel = 3'(IDX_HIT);
    tick();
    check_val("t3_hit_s",  32'(rd_s), 15);
    check_val("t3_hit_w",  32'(rd_w), 4);
    check_val("t3_ovf_a",  32'(ovf_a), 0);
    check_val("t3_ovf_s",  32'(ovf_s), 32'h07);
    check_val("t3_ovf_w",  32'(ovf_w), 32'h07);

    // Stalled request mostly with en=0; enable for the last stall and retire
    do_clr();
    en = 1'b0;
    drive(1'b1, 1'b0, 1'b1); tick(); tick();
    en = 1'b1;
    tick();
    drive(1'b1, 1'b0, 1'b0); tick();
    en = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    rd_chk("t4_req",   IDX_REQ,       1);
    rd_chk("t4_hit",   IDX_HIT,       0);
    rd_chk("t4_miss",  IDX_MISS,      1);
    rd_chk("t4_stall", IDX_STALL,     1);
    rd_chk("t4_max",   SEL_MAX_STALL, 3);

    // Drop req_valid in WAIT, then clear
    do_clr();
    en = 1'b1;
    drive(1'b1, 1'b0, 1'b1); tick(); tick();
    check_val("t5_busy", 32'(busy_a), 1);
    check_val("t5_perr0", 32'(pe_a), 0);
    drive(1'b0, 1'b0, 1'b0); tick();
    check_val("t5_perr1", 32'(pe_a), 1);
    check_val("t5_busy0", 32'(busy_a), 0);
    en = 1'b0;
    rd_chk("t5_req",    IDX_REQ,    0);
    rd_chk("t5_stall",  IDX_STALL,  2);
    rd_chk("t5_status", SEL_STATUS, 32'h80);
    do_clr();
    check_val("t5_perr_clr", 32'(pe_a), 0);
    for (int s = 0; s < 8; s++) begin
      rd_chk($sformatf("t5_clr_sel%0d", s), s, 0);
    end

    // Reset mid-WAIT, then an unstalled request is a hit
    do_clr();
    en = 1'b1;
    drive(1'b1, 1'b0, 1'b1); tick(); tick();
    check_val("t6_busy", 32'(busy_a), 1);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    tick();
    check_val("t6_rst_busy", 32'(busy_a), 0);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0); tick();
    en = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    check_val("t6_busy0", 32'(busy_a), 0);
    rd_chk("t6_hit",  IDX_HIT,       1);
    rd_chk("t6_miss", IDX_MISS,      0);
    rd_chk("t6_req",  IDX_REQ,       1);
    rd_chk("t6_max",  SEL_MAX_STALL, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_perf_monitor.md
Name: cache_perf_monitor

Overview:
- Parametrised performance-counter block observing the request/stall handshake between an instruction/trace source and the cache control unit.
- Classifies each retired request as a hit or a miss and counts cycles, requests, hits, misses and writes.
- Tracks total stall cycles and the longest single stall.
- Adds clear, enable, saturating/wrapping modes, sticky overflow flags and a registered readout mux for the board display.

Parameters:
- CNT_WIDTH, 16, width of every event counter and of rd_data.
- STALL_WIDTH, 8, width of the per-request stall-length counter and of max_stall.
- SATURATE, 1, 1 = counters clamp at all-ones; 0 = counters wrap to 0.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset (rst==0 resets at clk edge)
- en  in  1  1 = counters update; 0 = counters hold
- clr  in  1  synchronous clear of counters, flags and FSM
- req_valid  in  1  request presented to cache this cycle
- req_write  in  1  presented request is a write (meaningful when req_valid)
- stall  in  1  cache stall; request not accepted this cycle
- sel  in  3  readout select
- rd_data  out  CNT_WIDTH  registered selected counter
- ovf  out  6  sticky overflow flags, one per counter index 0..5
- proto_err  out  1  sticky: req_valid dropped while stalled
- busy  out  1  FSM in WAIT

Behaviour:
- Reset (rst==0) and clr==1: all counters, max_stall, cur_stall, ovf, proto_err, rd_data = 0; FSM = IDLE; busy = 0. Reset has priority over clr, and clr over en.
- FSM states:
  - IDLE:
    - req_valid & !stall: retire HIT, stay IDLE.
    - req_valid & stall: go WAIT, cur_stall = 1.
    - else: stay IDLE.
  - WAIT:
    - req_valid & stall: cur_stall += 1, saturating at all-ones regardless of SATURATE.
    - req_valid & !stall: retire MISS, max_stall = max(max_stall, cur_stall), go IDLE.
    - !req_valid: set proto_err, go IDLE, count nothing.
- busy = (state == WAIT).
- Stall with !req_valid in IDLE is ignored.
- The FSM advances regardless of en. Only counter and max_stall updates are gated by en, so classification stays correct across enable toggles.
- Counter indices and increment conditions (all gated by en):
  - 0 cyc: every cycle.
  - 1 req: every retire.
  - 2 hit: HIT retire.
  - 3 miss: MISS retire.
  - 4 wr: retire with req_write==1, sampled on the retire cycle.
  - 5 stall_cyc: every cycle with state==WAIT or a transition into WAIT, i.e. each cycle req_valid & stall.
- Invariant while no ovf bit is set: req == hit + miss, and stall_cyc == sum of all cur_stall values at MISS retire.
- Overflow when a counter at all-ones would increment:
  - SATURATE=1: counter holds all-ones and its ovf bit sets.
  - SATURATE=0: counter wraps to 0 and its ovf bit sets.
  - ovf bits clear only on reset or clr.
- Readout: rd_data <= counter[sel] for sel 0..5, zero-extended max_stall for sel 6, and {proto_err, busy, ovf} zero-extended for sel 7.
  - Latency: 1 cycle after sel.
  - rd_data updates even when en==0.
- Simultaneous events in one cycle: cycle, req, hit/miss and wr counters all increment together. A request retires in the same cycle clr is asserted is not counted.
- Reset or clr mid-WAIT abandons the request without counting it. If req_valid & !stall follows in the next cycle, it is classified as a HIT.

Decomposition:
- Shared package cache_perf_pkg:
  - counter index constants IDX_CYC..IDX_STALL (0..5), SEL_MAX_STALL = 6, SEL_STATUS = 7.
  - FSM state encoding IDLE/WAIT.
- Sub-module perf_counter (params WIDTH, SATURATE):
  - ports clk, rst, clr, inc, count, ovf.
  - instantiated six times.

Test Plan:
- Reset, then 4 back-to-back req_valid cycles with stall=0 (writes on 2nd and 4th) -> cyc=4, req=4, hit=4, miss=0, wr=2, stall_cyc=0.
- One request stalled 3 cycles then accepted, then a second request stalled 1 cycle then accepted -> miss=2, hit=0, stall_cyc=4, max_stall=3 (sel=6 reads 3 one cycle later).
- CNT_WIDTH=4, SATURATE=1, 20 hit retires -> req=15, hit=15, ovf[1]=ovf[2]=1. Same with SATURATE=0 -> req=4, ovf[1]=1.
- Hold en=0 across a stalled request: accept the request with en=1 on the retire cycle -> counted as a miss. Stall cycles while en=0 are not in stall_cyc; max_stall uses the full cur_stall.
- In WAIT, drop req_valid -> proto_err=1, busy=0, req unchanged; then clr=1 -> all reads 0, proto_err=0.
- Assert rst=0 mid-WAIT, release, present req_valid & !stall -> hit=1, miss=0, busy=0.
